fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'd0, word address loaded into PC on reset.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: PC  output  32  word address presented to instruction memory.
REQ-005 Port: Instruction  input  32  combinational instruction memory data for the current PC.
REQ-006 Port: redirect_valid  input  1  downstream branch/JR resolved taken.
REQ-007 Port: redirect_target  input  32  word address to fetch after redirect.
REQ-008 Port: halt_req  input  1  stop fetching.
REQ-009 Port: out_valid  output  1  buffer head holds a fetched instruction.
REQ-010 Port: out_ready  input  1  decode accepts head this cycle.
REQ-011 Port: out_instr  output  32  head instruction.
REQ-012 Port: out_pc  output  32  head instruction address.
REQ-013 Port: out_link  output  32  head address + 1, the JAL return address.
REQ-014 Port: halted  output  1  FSM is in HALT.

Function
REQ-015 FSM states SHALL be BOOT, RUN and HALT.
REQ-016 Reset SHALL force BOOT; BOOT SHALL go to RUN after exactly one cycle without fetching.
REQ-017 RUN SHALL go to HALT when halt_req=1 and redirect_valid=0.
REQ-018 HALT SHALL go to RUN only on redirect_valid=1, with PC loaded from redirect_target.
REQ-019 Buffer: 2-entry FIFO of {pc, instr, link}; count 0..2; out_valid = (count!=0).
REQ-020 Pop SHALL occur when out_valid and out_ready are both 1; the head advances at the next edge.
REQ-021 Push SHALL occur in RUN when redirect_valid=0, halt_req=0, and (count<2 or pop); the entry is {PC, Instruction, PC+1} sampled this cycle.
REQ-022 Full with no pop SHALL hold PC and push nothing (stall).
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 Next PC on push: if Instruction[31:26]=000001 (J) or 000010 (JAL), PC+1+sign_extend(Instruction[15:0]); otherwise PC+1.
REQ-025 All PC arithmetic SHALL be modulo 2^32, with wrap-around from 0xFFFFFFFF to 0 and no flag.
REQ-026 redirect_valid=1 SHALL take priority over halt_req, push and pop.
REQ-027 On redirect, count SHALL become 0, PC SHALL become redirect_target, and there SHALL be no push that cycle.
REQ-028 On redirect, a concurrent out_ready SHALL still count as consuming the presented head; the flushed entries SHALL be discarded silently.
REQ-029 Redirect while in BOOT SHALL be ignored.
REQ-030 HALT SHALL hold PC; the buffer SHALL continue to drain via pop.
REQ-031 halted SHALL be 1 only in HALT.
REQ-032 Branch opcodes and JR (000011) SHALL not alter PC inside this block; they pass through and are resolved only via redirect.
REQ-033 When out_valid=0, out_instr, out_pc and out_link SHALL be 0.

Reset
REQ-034 On rst_n=0, asynchronously: PC=RESET_PC, count=0, state=BOOT, out_valid=0, out_instr=0, out_pc=0, out_link=0, halted=0.
REQ-035 Reset asserted mid-operation SHALL discard all buffered entries and any pending redirect; fetch SHALL restart at RESET_PC two edges after rst_n rises.

Verification
REQ-036 Straight-line fetch: memory returns nonzero non-jump words, out_ready=1 constantly -> out_pc sequence 0,1,2,3... one per cycle after BOOT, out_link=out_pc+1.
REQ-037 Jump: J at PC 18 with imm 0x0002 -> next fetched PC 21; JAL at PC 2 with imm 0x0007 -> next PC 10, out_link=3 for the JAL entry.
REQ-038 Backpressure: out_ready=0 for 5 cycles -> count saturates at 2, PC frozen at 2, no entry lost or duplicated after release.
REQ-039 Redirect with count=2 and out_ready=1 -> next edge: count=0, PC=redirect_target (e.g. 10), then first out_pc=10.
REQ-040 Halt then redirect: halt_req at PC 5 -> halted=1, PC held at 5; redirect_target=0 -> RUN, next out_pc=0.
REQ-041 Wrap and async reset: PC=0xFFFFFFFF with a non-jump word -> next PC 0; rst_n low mid-stream -> outputs zero immediately, first out_pc=RESET_PC after release.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-side bus between the fetch unit, instruction memory and decode.
// Signals:
//   PC              fetch address presented to instruction memory
//   Instruction     combinational memory data for PC
//   redirect_valid  taken branch/JR resolved downstream
//   redirect_target word address to fetch after a redirect
//   halt_req        stop fetching
//   out_valid/out_ready  head-of-buffer handshake toward decode
//   out_instr/out_pc/out_link  head entry (link = pc + 1)
//   halted          fetch FSM is parked in HALT
// master = fetch unit side, slave = memory/decode side.
interface fetch_if;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_link;
    logic        halted;

    modport master (
        output PC, out_valid, out_instr, out_pc, out_link, halted,
        input  Instruction, redirect_valid, redirect_target, halt_req, out_ready
    );

    modport slave (
        input  PC, out_valid, out_instr, out_pc, out_link, halted,
        output Instruction, redirect_valid, redirect_target, halt_req, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a 2-entry output buffer.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_if.master (PC/Instruction to memory, redirect/halt in,
//          out_* handshake toward decode, halted status)
// Parameter RESET_PC: word address fetched first after reset.
//
// state | meaning
// ------+---------------------------------------------------------
// BOOT  | one idle cycle after reset, no fetch, redirects ignored
// RUN   | fetching; push one entry per cycle unless stalled
// HALT  | PC held, buffer drains; leaves only on redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input logic    clk,
    input logic    rst_n,
    fetch_if.master bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] link;
    } entry_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    entry_t      ent_q [2];
    entry_t      ent_d [2];
    logic        halted_q;

    logic        valid;
    logic        pop;
    logic        redirect;
    logic        push;
    logic        is_jump;
    logic [31:0] pc_plus1;
    logic [31:0] next_pc;
    entry_t      new_ent;

    assign valid    = (count_q != 2'd0);
    assign pop      = valid && bus.out_ready;
    // A redirect during BOOT is dropped; everywhere else it wins over all.
    assign redirect = bus.redirect_valid && (state_q != ST_BOOT);
    assign push     = (state_q == ST_RUN) && !bus.redirect_valid && !bus.halt_req
                      && ((count_q != 2'd2) || pop);

    assign pc_plus1 = pc_q + 32'd1;
    // Only J/JAL are resolved here; branches and JR pass through untouched.
    assign is_jump  = (bus.Instruction[31:26] == 6'b000001) ||
                      (bus.Instruction[31:26] == 6'b000010);
    assign next_pc  = is_jump ? pc_plus1 + {{16{bus.Instruction[15]}}, bus.Instruction[15:0]}
                              : pc_plus1;
    assign new_ent  = '{pc: pc_q, instr: bus.Instruction, link: pc_plus1};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        ent_d   = ent_q;
        if (redirect) begin
            // Flush: any head consumed this cycle is simply gone with the rest.
            state_d = ST_RUN;
            pc_d    = bus.redirect_target;
            count_d = 2'd0;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN:  if (bus.halt_req) state_d = ST_HALT;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_BOOT;
            endcase
            if (pop) begin
                ent_d[0] = ent_q[1];
                count_d  = count_q - 2'd1;
            end
            if (push) begin
                // Write into the slot just behind the (post-pop) tail.
                if (count_d == 2'd0) begin
                    ent_d[0] = new_ent;
                end else begin
                    ent_d[1] = new_ent;
                end
                count_d = count_d + 2'd1;
                pc_d    = next_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
            halted_q <= (state_d == ST_HALT);
        end
    end

    assign bus.PC        = pc_q;
    assign bus.out_valid = valid;
    assign bus.out_instr = valid ? ent_q[0].instr : 32'd0;
    assign bus.out_pc    = valid ? ent_q[0].pc    : 32'd0;
    assign bus.out_link  = valid ? ent_q[0].link  : 32'd0;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected
// {pc, instr, link} entries; a negedge monitor pops and compares on every
// accepted head and checks zeroed outputs whenever the buffer is empty.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] link;
    } exp_t;

    logic clk;
    logic rst_n;
    logic jumps_en;
    int   checks;
    int   errors;
    int   pop_cnt;
    exp_t exp_q[$];

    fetch_if bus();

    fetch_unit #(.RESET_PC(32'd0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic jen);
        logic [31:0] w;
        w = {6'b100000, 10'd0, a[15:0]};
        if (jen) begin
            case (a)
                32'd2:   w = {6'b000010, 10'd0, 16'h0007};
                32'd11:  w = {6'b000011, 10'd0, 16'h0005};
                32'd12:  w = {6'b000100, 10'd0, 16'h0003};
                32'd18:  w = {6'b000001, 10'd0, 16'h0002};
                default: w = {6'b100000, 10'd0, a[15:0]};
            endcase
        end
        return w;
    endfunction

    always_comb bus.Instruction = mem_word(bus.PC, jumps_en);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %h expected no entry", bus.out_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_pc", bus.out_pc, e.pc);
                    chk("sb_instr", bus.out_instr, e.instr);
                    chk("sb_link", bus.out_link, e.link);
                    pop_cnt++;
                end
            end else if (!bus.out_valid) begin
                chk("idle_zero", bus.out_pc | bus.out_instr | bus.out_link, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a);
        exp_q.push_back('{pc: a, instr: mem_word(a, jumps_en), link: a + 32'd1});
    endtask

    task automatic push_range(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) push_one(a + 32'(i));
    endtask

    task automatic do_reset();
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'd0;
        bus.halt_req       = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_outs", bus.out_pc | bus.out_instr | bus.out_link, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_pc", bus.PC, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        pop_cnt = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pop_cnt = 0;
        jumps_en = 1'b0;
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'd0;
        bus.halt_req = 1'b0;
        #2;

        // Straight-line fetch
        do_reset();
        bus.out_ready = 1'b1;
        push_range(0, 12);
        tick();
        chk("boot_pc", bus.PC, 32'd0);
        chk("boot_valid", {31'd0, bus.out_valid}, 32'd0);
        repeat (8) tick();
        bus.out_ready = 1'b0;
        chk("line_pops", pop_cnt, 32'd7);

        // Jumps (JAL at 2, J at 18), JR/branch pass-through at 11/12
        jumps_en = 1'b1;
        do_reset();
        bus.out_ready = 1'b1;
        push_range(0, 3);
        push_range(10, 9);
        push_range(21, 8);
        repeat (16) tick();
        bus.out_ready = 1'b0;
        chk("jump_pops", pop_cnt, 32'd14);
        jumps_en = 1'b0;

        // Backpressure
        do_reset();
        push_range(0, 12);
        repeat (6) tick();
        chk("bp_pc", bus.PC, 32'd2);
        chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_head", bus.out_pc, 32'd0);
        bus.out_ready = 1'b1;
        repeat (6) tick();
        bus.out_ready = 1'b0;
        chk("bp_pops", pop_cnt, 32'd6);
        chk("bp_pc_after", bus.PC, 32'd8);

        // Redirect with a full buffer and out_ready high
        do_reset();
        push_range(0, 6);
        repeat (4) tick();
        chk("rd_pc_full", bus.PC, 32'd2);
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'd10;
        tick();
        chk("rd_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rd_pc", bus.PC, 32'd10);
        chk("rd_head_pop", pop_cnt, 32'd1);
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        push_range(10, 8);
        repeat (5) tick();
        bus.out_ready = 1'b0;
        chk("rd_pops", pop_cnt, 32'd5);

        // Halt at PC 5, then redirect to 0
        do_reset();
        bus.out_ready = 1'b1;
        push_range(0, 12);
        repeat (6) tick();
        chk("h_pc_pre", bus.PC, 32'd5);
        bus.halt_req = 1'b1;
        tick();
        chk("h_halted", {31'd0, bus.halted}, 32'd1);
        chk("h_pc", bus.PC, 32'd5);
        repeat (2) tick();
        chk("h_pc_hold", bus.PC, 32'd5);
        chk("h_drained", {31'd0, bus.out_valid}, 32'd0);
        chk("h_pops", pop_cnt, 32'd5);
        bus.halt_req = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'd0;
        tick();
        chk("h_run", {31'd0, bus.halted}, 32'd0);
        chk("h_pc_redir", bus.PC, 32'd0);
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        push_range(0, 8);
        repeat (4) tick();
        bus.out_ready = 1'b0;
        chk("h_pops2", pop_cnt, 32'd8);

        // Redirect in BOOT ignored, PC wrap, async reset mid-stream
        do_reset();
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h55;
        tick();
        chk("boot_redir_ignored", bus.PC, 32'd0);
        bus.redirect_target = 32'hFFFF_FFFF;
        tick();
        chk("w_pc_max", bus.PC, 32'hFFFF_FFFF);
        bus.redirect_valid = 1'b0;
        push_one(32'hFFFF_FFFF);
        push_range(0, 10);
        tick();
        chk("w_pc_wrap", bus.PC, 32'd0);
        repeat (3) tick();
        chk("w_pops", pop_cnt, 32'd3);
        chk("w_valid_pre_rst", {31'd0, bus.out_valid}, 32'd1);
        do_reset();
        bus.out_ready = 1'b1;
        push_range(0, 6);
        tick();
        chk("r_pc", bus.PC, 32'd0);
        repeat (3) tick();
        bus.out_ready = 1'b0;
        chk("r_pops", pop_cnt, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
